// File: rtl/memcached_pkt_gen.sv
// memcached_pkt_gen: emits memcached-over-UDP SET/GET packets as 64-bit
// AXI4-Stream beats on one of NUM_PORTS master channels. A single lane of
// registered beat state is decoded onto the selected port. Every other port
// reads as zero.
module memcached_pkt_gen #(
  parameter int NUM_PORTS   = 5,
  parameter int VALUE_WORDS = 8,
  parameter int PAD_WORDS   = 8,
  parameter int GAP_W       = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic [1:0]              mode,
  input  logic [15:0]             pkt_count,
  input  logic [GAP_W-1:0]        gap,
  input  logic [7:0]              key,
  input  logic [2:0]              port_sel,
  input  logic                    rr_en,
  output logic [NUM_PORTS*64-1:0] m_axis_tdata,
  output logic [NUM_PORTS*8-1:0]  m_axis_tkeep,
  output logic [NUM_PORTS-1:0]    m_axis_tvalid,
  output logic [NUM_PORTS-1:0]    m_axis_tlast,
  input  logic [NUM_PORTS-1:0]    m_axis_tready,
  output logic                    busy,
  output logic [15:0]             pkts_sent
);

  localparam int IDX_W = 9;
  localparam logic [IDX_W-1:0] SET_LAST = IDX_W'(8 + VALUE_WORDS - 1);
  localparam logic [IDX_W-1:0] GET_LAST = IDX_W'(6 + PAD_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  // Word idx of a SET (is_get=0) or GET (is_get=1) packet, with key in word 5.
  function automatic logic [63:0] pkt_word(input logic is_get,
                                           input logic [IDX_W-1:0] idx,
                                           input logic [7:0] k);
    logic [63:0] w;
    w = 64'h0;
    if (is_get) begin
      case (idx)
        9'd0:    w = 64'h0000FFFFFFFFFFFF;
        9'd1:    w = 64'h0145000800000000;
        9'd2:    w = 64'h1140000001005C00;
        9'd3:    w = 64'hA8C000000000E1B9;
        9'd4:    w = 64'h4800393035000600;
        9'd5:    w = 64'h5A3030303030E1F4;
        default: w = 64'h4141414141414141;
      endcase
    end else begin
      case (idx)
        9'd0:    w = 64'h0000FFFFFFFFFFFF;
        9'd1:    w = 64'h0045000800000000;
        9'd2:    w = 64'h1140000001000600;
        9'd3:    w = 64'hA8C000000000D9B9;
        9'd4:    w = 64'h6800CB2B40C20100;
        9'd5:    w = 64'h5A30303030309896;
        9'd6:    w = 64'h2061207565730000;
        9'd7:    w = 64'h0A0D323720302030;
        // value word i = idx-8 ends in 0x31+i, i.e. 0x29+idx modulo 256
        default: w = {56'h46454542444145, 8'h29 + idx[7:0]};
      endcase
    end
    if (idx == 9'd5) w[63:56] = k;
    return w;
  endfunction

  state_t             r_state;
  logic               r_valid;
  logic               r_last;
  logic [63:0]        r_data;
  logic [2:0]         r_port;
  logic [IDX_W-1:0]   r_idx;
  logic               r_is_get;
  logic               r_busy;
  logic [15:0]        r_pkts;
  logic               r_stop_pend;
  logic               r_alt;
  logic [15:0]        r_cnt;
  logic [GAP_W-1:0]   r_gap;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [7:0]         r_key;
  logic               r_rr;

  logic [NUM_PORTS-1:0] w_sel;
  logic                 w_hs;
  logic                 w_end;
  logic                 w_next_get;
  logic [2:0]           w_next_port;
  logic [2:0]           w_start_port;
  logic [IDX_W-1:0]     w_last_idx;

  assign w_hs         = |(w_sel & m_axis_tready);
  assign w_end        = ((r_cnt != 16'd0) && (r_pkts + 16'd1 == r_cnt)) || r_stop_pend || stop;
  assign w_next_get   = r_alt ? ~r_is_get : r_is_get;
  assign w_next_port  = !r_rr ? r_port :
                        (r_port == 3'(NUM_PORTS - 1)) ? 3'd0 : r_port + 3'd1;
  assign w_start_port = ({1'b0, port_sel} >= 4'(NUM_PORTS)) ? 3'd0 : port_sel;
  assign w_last_idx   = r_is_get ? GET_LAST : SET_LAST;

  // Run control and beat sequencing; one beat register feeds all ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_data      <= 64'h0;
      r_port      <= 3'd0;
      r_idx       <= '0;
      r_is_get    <= 1'b0;
      r_busy      <= 1'b0;
      r_pkts      <= 16'd0;
      r_stop_pend <= 1'b0;
      r_alt       <= 1'b0;
      r_cnt       <= 16'd0;
      r_gap       <= '0;
      r_gap_cnt   <= '0;
      r_key       <= 8'd0;
      r_rr        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_stop_pend <= 1'b0;
          if (start) begin
            r_alt    <= mode[1];
            r_cnt    <= pkt_count;
            r_gap    <= gap;
            r_key    <= key;
            r_rr     <= rr_en;
            r_is_get <= (mode == 2'd1);
            r_port   <= w_start_port;
            r_pkts   <= 16'd0;
            r_idx    <= '0;
            r_data   <= pkt_word(mode == 2'd1, '0, key);
            r_last   <= 1'b0;
            r_valid  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_SEND;
          end
        end
        S_SEND: begin
          if (stop) r_stop_pend <= 1'b1;
          if (w_hs) begin
            if (r_last) begin
              r_pkts <= r_pkts + 16'd1;
              r_idx  <= '0;
              r_last <= 1'b0;
              if (w_end) begin
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                // Preload the next packet's first word; it is masked during a gap.
                r_is_get <= w_next_get;
                r_port   <= w_next_port;
                r_data   <= pkt_word(w_next_get, '0, r_key);
                if (r_gap != '0) begin
                  r_valid   <= 1'b0;
                  r_gap_cnt <= r_gap - GAP_W'(1);
                  r_state   <= S_GAP;
                end
              end
            end else begin
              r_idx  <= r_idx + 9'd1;
              r_data <= pkt_word(r_is_get, r_idx + 9'd1, r_key);
              r_last <= (r_idx + 9'd1 == w_last_idx);
            end
          end
        end
        S_GAP: begin
          if (stop) r_stop_pend <= 1'b1;
          if (r_gap_cnt == '0) begin
            r_valid <= 1'b1;
            r_state <= S_SEND;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Per-port outputs are decodes of registered state only, never of tready.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign w_sel[gi]                    = r_valid && (r_port == 3'(gi));
    assign m_axis_tvalid[gi]            = w_sel[gi];
    assign m_axis_tlast[gi]             = w_sel[gi] && r_last;
    assign m_axis_tkeep[gi*8 +: 8]      = w_sel[gi] ? 8'hFF : 8'h00;
    assign m_axis_tdata[gi*64 +: 64]    = w_sel[gi] ? r_data : 64'h0;
  end

  assign busy      = r_busy;
  assign pkts_sent = r_pkts;

endmodule

// File: tb/tb_memcached_pkt_gen.sv
// Testbench for memcached_pkt_gen: a packet model fills a beat scoreboard at
// each start, and a monitor pops and compares every handshaked beat.
module tb_memcached_pkt_gen;

  localparam int NP = 5;

  localparam logic [63:0] SET_HDR [8] = '{
    64'h0000FFFFFFFFFFFF, 64'h0045000800000000, 64'h1140000001000600,
    64'hA8C000000000D9B9, 64'h6800CB2B40C20100, 64'h5A30303030309896,
    64'h2061207565730000, 64'h0A0D323720302030};
  localparam logic [63:0] GET_HDR [6] = '{
    64'h0000FFFFFFFFFFFF, 64'h0145000800000000, 64'h1140000001005C00,
    64'hA8C000000000E1B9, 64'h4800393035000600, 64'h5A3030303030E1F4};

  logic            clk, reset, start, stop, rr_en, busy;
  logic [1:0]      mode;
  logic [15:0]     pkt_count, pkts_sent;
  logic [7:0]      gap, key;
  logic [2:0]      port_sel;
  logic [NP*64-1:0] m_axis_tdata;
  logic [NP*8-1:0]  m_axis_tkeep;
  logic [NP-1:0]    m_axis_tvalid, m_axis_tlast, m_axis_tready;

  typedef struct {
    int         port;
    logic [63:0] data;
    bit         last;
  } beat_t;

  typedef struct {
    logic [1:0] mode;
    int         cnt;
    int         gap;
    logic [7:0] key;
    logic [2:0] psel;
    bit         rr;
    bit         bp;
  } tcase_t;

  beat_t  q[$];
  tcase_t tbl[6];
  int     tests = 0;
  int     fails = 0;
  int     exp_gap = 0;
  int     beats_seen = 0;
  bit     bp = 0;

  memcached_pkt_gen #(.NUM_PORTS(NP), .VALUE_WORDS(8), .PAD_WORDS(8), .GAP_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .pkt_count(pkt_count), .gap(gap), .key(key), .port_sel(port_sel), .rr_en(rr_en),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .busy(busy), .pkts_sent(pkts_sent));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // tready changes just after each rising edge; random only when bp is set
  initial begin
    m_axis_tready = '1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = bp ? NP'($urandom) : '1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_word(input bit is_get, input int idx, input logic [7:0] k);
    logic [63:0] w;
    logic [7:0]  b;
    if (!is_get) begin
      if (idx < 8) w = SET_HDR[idx];
      else begin
        b = 8'h31 + 8'(idx - 8);
        w = {56'h46454542444145, b};
      end
    end else begin
      w = (idx < 6) ? GET_HDR[idx] : 64'h4141414141414141;
    end
    if (idx == 5) w[63:56] = k;
    return w;
  endfunction

  // Push every expected beat of a run of n packets onto the scoreboard.
  task automatic push_run(input logic [1:0] md, input int n, input logic [7:0] k,
                          input logic [2:0] ps, input bit rr);
    int    sp;
    beat_t b;
    bit    g;
    int    len;
    sp = (ps >= NP) ? 0 : int'(ps);
    for (int p = 0; p < n; p++) begin
      g   = (md == 2'd1) ? 1'b1 : (md >= 2'd2) ? (p % 2 == 1) : 1'b0;
      len = g ? 14 : 16;
      for (int i = 0; i < len; i++) begin
        b.port = rr ? (sp + p) % NP : sp;
        b.data = exp_word(g, i, k);
        b.last = (i == len - 1);
        q.push_back(b);
      end
    end
  endtask

  // Beat monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    int          active, nvalid;
    bit          bad;
    beat_t       e;
    static bit          prev_stall = 0;
    static bit          counting = 0;
    static int          idle_cnt = 0;
    static int          prev_port = 0;
    static logic [63:0] prev_data = 0;
    static logic        prev_last = 0;
    if (reset) begin
      prev_stall = 0;
      counting   = 0;
    end else begin
      active = -1;
      nvalid = 0;
      bad    = 0;
      for (int p = 0; p < NP; p++) if (m_axis_tvalid[p]) begin nvalid++; active = p; end
      for (int p = 0; p < NP; p++)
        if (p != active && (m_axis_tdata[p*64 +: 64] != 64'h0 || m_axis_tkeep[p*8 +: 8] != 8'h0 || m_axis_tlast[p]))
          bad = 1;
      chk("inactive_ports_zero", {63'h0, (nvalid > 1) || bad}, 64'h0);
      if (prev_stall) begin
        chk("hold_port", 64'(active), 64'(prev_port));
        if (active >= 0) begin
          chk("hold_data", m_axis_tdata[active*64 +: 64], prev_data);
          chk("hold_last", {63'h0, m_axis_tlast[active]}, {63'h0, prev_last});
        end
      end
      if (active >= 0) begin
        if (counting) begin
          chk("gap_cycles", 64'(idle_cnt), 64'(exp_gap));
          counting = 0;
        end
        chk("tkeep", {56'h0, m_axis_tkeep[active*8 +: 8]}, 64'hFF);
        if (m_axis_tready[active]) begin
          beats_seen++;
          prev_stall = 0;
          if (q.size() == 0) begin
            chk("unexpected_beat", m_axis_tdata[active*64 +: 64], 64'h0);
            if (m_axis_tdata[active*64 +: 64] == 64'h0) chk("unexpected_beat_port", 64'(active), 64'hFFFF);
          end else begin
            e = q.pop_front();
            chk("beat_port", 64'(active), 64'(e.port));
            chk("beat_data", m_axis_tdata[active*64 +: 64], e.data);
            chk("beat_last", {63'h0, m_axis_tlast[active]}, {63'h0, e.last});
            if (e.last && q.size() != 0) begin
              counting = 1;
              idle_cnt = 0;
            end
          end
        end else begin
          prev_stall = 1;
          prev_port  = active;
          prev_data  = m_axis_tdata[active*64 +: 64];
          prev_last  = m_axis_tlast[active];
        end
      end else begin
        prev_stall = 0;
        if (counting) idle_cnt++;
      end
    end
  end

  // Drive a one-cycle start with the given configuration, then confirm busy.
  task automatic pulse_start(input logic [1:0] md, input int n, input int gp,
                             input logic [7:0] k, input logic [2:0] ps, input bit rr);
    mode = md; pkt_count = 16'(n); gap = 8'(gp); key = k; port_sel = ps; rr_en = rr;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", {63'h0, busy}, 64'h1);
    chk("pkts_cleared", {48'h0, pkts_sent}, 64'h0);
    chk("first_beat_valid", {63'h0, |m_axis_tvalid}, 64'h1);
  endtask

  // Wait (bounded) for the scoreboard to drain, then check the run ended cleanly.
  task automatic finish_run(input int exp_pkts);
    int cyc;
    cyc = 0;
    while (q.size() != 0 && cyc < 5000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("drain_timeout", 64'(q.size()), 64'h0);
    @(negedge clk);
    #1;
    chk("busy_end", {63'h0, busy}, 64'h0);
    chk("pkts_sent", {48'h0, pkts_sent}, 64'(exp_pkts));
    chk("idle_after_run", {59'h0, m_axis_tvalid}, 64'h0);
    q.delete();
    repeat (20) @(posedge clk);
    bp = 0;
    @(posedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0; pkt_count = 16'd0;
    gap = 8'd0; key = 8'd0; port_sel = 3'd0; rr_en = 1'b0;

    tbl[0] = '{mode: 2'd0, cnt: 1, gap: 0, key: 8'h5A, psel: 3'd0, rr: 1'b0, bp: 1'b0};
    tbl[1] = '{mode: 2'd2, cnt: 4, gap: 3, key: 8'h5A, psel: 3'd0, rr: 1'b0, bp: 1'b0};
    tbl[2] = '{mode: 2'd0, cnt: 1, gap: 0, key: 8'h5A, psel: 3'd0, rr: 1'b0, bp: 1'b1};
    tbl[3] = '{mode: 2'd3, cnt: 6, gap: 0, key: 8'hA5, psel: 3'd3, rr: 1'b1, bp: 1'b0};
    tbl[4] = '{mode: 2'd1, cnt: 2, gap: 1, key: 8'hC3, psel: 3'd6, rr: 1'b0, bp: 1'b1};
    tbl[5] = '{mode: 2'd2, cnt: 3, gap: 2, key: 8'h00, psel: 3'd4, rr: 1'b1, bp: 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", {59'h0, m_axis_tvalid}, 64'h0);
    chk("rst_tlast", {59'h0, m_axis_tlast}, 64'h0);
    chk("rst_tkeep", {24'h0, m_axis_tkeep}, 64'h0);
    chk("rst_tdata_or", {63'h0, |m_axis_tdata}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_pkts", {48'h0, pkts_sent}, 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      exp_gap = tbl[i].gap;
      bp      = tbl[i].bp;
      push_run(tbl[i].mode, tbl[i].cnt, tbl[i].key, tbl[i].psel, tbl[i].rr);
      pulse_start(tbl[i].mode, tbl[i].cnt, tbl[i].gap, tbl[i].key, tbl[i].psel, tbl[i].rr);
      finish_run(tbl[i].cnt);
      #1;
    end

    // Continuous run, stop pulsed inside packet 3 together with an ignored start.
    exp_gap = 0;
    push_run(2'd0, 3, 8'h11, 3'd1, 1'b0);
    pulse_start(2'd0, 0, 0, 8'h11, 3'd1, 1'b0);
    repeat (38) @(posedge clk);
    #1;
    stop = 1'b1; start = 1'b1; mode = 2'd1;
    @(posedge clk);
    #1;
    stop = 1'b0; start = 1'b0;
    finish_run(3);
    #1;

    // Stop and start both land on the tlast handshake of the first GET packet.
    exp_gap = 2;
    push_run(2'd1, 1, 8'h22, 3'd2, 1'b0);
    pulse_start(2'd1, 0, 2, 8'h22, 3'd2, 1'b0);
    repeat (13) @(posedge clk);
    #1;
    stop = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0; start = 1'b0;
    finish_run(1);
    #1;

    // Reset in the middle of a packet, then a clean packet from word 0.
    push_run(2'd0, 1, 8'h33, 3'd2, 1'b0);
    pulse_start(2'd0, 1, 0, 8'h33, 3'd2, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_tvalid", {59'h0, m_axis_tvalid}, 64'h0);
    chk("midrst_tlast", {59'h0, m_axis_tlast}, 64'h0);
    chk("midrst_tdata_or", {63'h0, |m_axis_tdata}, 64'h0);
    chk("midrst_busy", {63'h0, busy}, 64'h0);
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_run(2'd0, 1, 8'h77, 3'd2, 1'b0);
    pulse_start(2'd0, 1, 0, 8'h77, 3'd2, 1'b0);
    finish_run(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memcached_pkt_gen.md
# memcached_pkt_gen

Synthesizable memcached-over-UDP traffic generator for the ualink_turbo64 fabric. It emits complete 64-bit AXI4-Stream SET and GET packets on one of NUM_PORTS master channels, with a configurable mode, packet count, inter-packet gap, key byte and port-selection policy. It sits in front of the ualink_turbo64 slave ports as an on-chip stimulus and loopback source, and replaces free-running bench stimulus with correct valid/ready semantics.

## Interface
- NUM_PORTS, 5: number of AXIS master channels (1..8).
- VALUE_WORDS, 8: 64-bit value words in a SET packet (1..255).
- PAD_WORDS, 8: 0x41-filler words after the GET header (1..255).
- GAP_W, 8: width of the inter-packet gap field.

- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle pulse that begins a run; ignored while busy.
- stop  in  1  pulse that requests the run end at the next packet boundary.
- mode  in  2  run mode: 0 = SET only, 1 = GET only, 2 and 3 = alternate, starting with SET.
- pkt_count  in  16  packets per run; 0 = continuous until stop.
- gap  in  GAP_W  idle cycles inserted after each tlast.
- key  in  8  key byte inserted into every packet.
- port_sel  in  3  fixed output port; a value >= NUM_PORTS maps to port 0.
- rr_en  in  1  1 = round-robin across ports, starting at port_sel.
- m_axis_tdata  out  NUM_PORTS*64  per-port data; port p occupies [64p+63:64p].
- m_axis_tkeep  out  NUM_PORTS*8  8'hFF on the active port, 0 elsewhere.
- m_axis_tvalid  out  NUM_PORTS  per-port valid.
- m_axis_tlast  out  NUM_PORTS  per-port last.
- m_axis_tready  in  NUM_PORTS  per-port ready.
- busy  out  1  high from the cycle after start is accepted until the run ends.
- pkts_sent  out  16  packets completed in the current or last run; wraps modulo 2^16.

## Operation
- The FSM has three states: IDLE, SEND and GAP. Reset enters IDLE.
- Configuration is latched when start is accepted. Inputs may change during a run with no effect, except stop.
- **IDLE:** busy=0. When start=1, the block latches the configuration, clears pkts_sent and word_idx, and enters SEND.
- **SEND:** the block drives word[word_idx] on the current port.
  - A beat completes on tvalid&&tready, and word_idx then increments.
  - On the tlast beat, pkts_sent increments.
  - If (pkt_count!=0 && pkts_sent+1==pkt_count) or stop is pending, the FSM goes to IDLE.
  - Otherwise, if gap==0, the FSM stays in SEND with word_idx=0.
  - Otherwise the FSM goes to GAP.
  - After each packet, the type toggles in alternate mode, and the port advances (p+1 mod NUM_PORTS) when rr_en=1.
- **GAP:** all tvalid are 0. The gap counter counts latched-gap cycles and then the FSM returns to SEND.
- stop is sticky until the run ends. It never truncates a packet. A stop in IDLE is ignored.
- **SET packet:** 8+VALUE_WORDS beats.
  - Header words 0..7: FFFFFFFFFFFF0000 with bytes reversed as 64'h0000FFFFFFFFFFFF, 0045000800000000, 1140000001000600, A8C000000000D9B9, 6800CB2B40C20100, 5A30303030309896, 2061207565730000, 0A0D323720302030.
  - Value word i: 64'h46454542444145 concatenated with low byte (8'h31+i) mod 256.
- **GET packet:** 6+PAD_WORDS beats.
  - Header words 0..5: 0000FFFFFFFFFFFF, 0145000800000000, 1140000001005C00, A8C000000000E1B9, 4800393035000600, 5A3030303030E1F4.
  - These are followed by PAD_WORDS × 4141414141414141.
- In both packet types, bits [63:56] of word 5 are replaced by key.
- Only the current port may assert tvalid, tlast and tkeep, and carry nonzero tdata. All other ports are driven 0.

## Timing
- Reset values: all tvalid, tlast, tkeep and tdata = 0; busy=0; pkts_sent=0; FSM=IDLE.
- A reset mid-packet drops tvalid on the next edge. No tlast is emitted.
- When start is sampled at edge N, busy=1 and the first beat is valid after edge N.
- While tvalid=1 && tready=0, tdata, tlast, tkeep and the port are held stable. tvalid never deasserts before the handshake.
- tvalid does not depend combinationally on tready. All outputs are registered.
- Throughput is 1 beat/cycle with tready held high.
- With gap=0, the first beat of the next packet follows the tlast beat with no bubble.
- With gap=G, exactly G cycles with tvalid=0 occur between packets.
- A stop arriving in the same cycle as a tlast handshake ends the run after that packet.
- A start arriving in the same cycle as the run's final tlast is ignored.

## Test plan
- **Single SET, port 0:** mode=0, pkt_count=1, gap=0, key=8'h5A, ready=1 → 16 beats on port 0. Word 8 = 4645454244414531 and word 15 = 4645454244414538. tlast only on beat 16. pkts_sent=1, and busy falls after the tlast.
- **Alternate with gap:** mode=2, pkt_count=4, gap=3 → SET(16), GET(14), SET, GET. Exactly 3 idle cycles between packets. The GET word 5 = 5A3030303030E1F4 and words 6..13 = 4141414141414141.
- **Backpressure:** random tready on port 0, SET packet → the data sequence matches the ready=1 run. tdata is stable whenever valid&&!ready, and no beat is dropped or duplicated.
- **Round-robin:** rr_en=1, port_sel=3, NUM_PORTS=5, pkt_count=6 → packets on ports 3,4,0,1,2,3. Inactive ports stay at 0 throughout.
- **Continuous plus stop:** pkt_count=0, stop is pulsed mid-packet 3 → packet 3 completes with tlast, then the run goes IDLE with pkts_sent=3. A start during the run is ignored.
- **Reset mid-packet:** reset asserted at beat 5 → the next edge shows all outputs 0 and FSM=IDLE. A new start produces a clean packet starting from word 0.
